char_ram_arbiter: RTL and testbench
===================================

Name: char_ram_arbiter

Overview:
Shares the single-port character RAM between two masters. The video fetch path reads the RAM every active-display cycle and always has priority. Character writes from the command handler are queued in a small FIFO and drained into the RAM only on cycles when video is not using the port. The block sits between the command handler's char write outputs, the video scan logic and the character RAM.

Parameters:
ADDR_BITS, 11, character RAM address width.
DEPTH, 4, write FIFO entries; must be a power of 2 and at least 2.
PTR_BITS, 2, log2(DEPTH).

Ports:
clk  in  1  system clock, rising edge.
clr_n  in  1  asynchronous active-low reset.
wr_char  in  8  character code to write.
wr_addr  in  ADDR_BITS  RAM address to write.
wr_en  in  1  write request, sampled each cycle.
wr_ready  out  1  FIFO can accept a write this cycle.
wr_overflow  out  1  sticky flag: a write was dropped.
ovf_clr  in  1  synchronous clear of wr_overflow.
fifo_count  out  PTR_BITS+1  current FIFO occupancy.
vid_req  in  1  video needs the port this cycle.
vid_addr  in  ADDR_BITS  video read address.
vid_data  out  8  read data, equal to ram_dout.
vid_valid  out  1  vid_data valid; this is vid_req delayed by one cycle.
ram_addr  out  ADDR_BITS  RAM address.
ram_din  out  8  RAM write data.
ram_we  out  1  RAM write enable.
ram_dout  in  8  RAM synchronous read data, 1-cycle latency.

Behaviour:
- Reset (clr_n low, asynchronous): FIFO empty, all pointers 0, fifo_count=0, wr_overflow=0, vid_valid=0.
- After reset, with no vid_req: wr_ready=1 and ram_we=0.
- Reset mid-drain discards all queued writes. No partial write is issued after release.
- wr_ready = (fifo_count != DEPTH). It is decoded from registered state only and never depends on the same-cycle pop.
- Push: on a clock edge where wr_en=1 and wr_ready=1, store {wr_char, wr_addr} at the write pointer.
- Drop: wr_en=1 with wr_ready=0 discards the write and sets wr_overflow on that edge.
- wr_overflow stays set until ovf_clr=1. If a drop and ovf_clr occur on the same edge, set wins.
- Port mux (combinational):
  - If vid_req=1: ram_addr=vid_addr, ram_we=0.
  - Else if FIFO not empty: ram_addr=head addr, ram_din=head char, ram_we=1.
  - Else: ram_addr=vid_addr, ram_we=0.
- ram_din always shows the head char. It is don't-care when ram_we=0.
- Pop: on any edge where ram_we=1, the read pointer advances.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- Push while full with a same-cycle pop: the push is dropped, because wr_ready was 0.
- Pointers are PTR_BITS wide and wrap modulo DEPTH. fifo_count is PTR_BITS+1 wide, so it can hold DEPTH.
- Write latency: a write accepted at edge N reaches the RAM port in cycle N+1 at the earliest. It is delayed by one cycle for every cycle vid_req stays high.
- Ordering: writes reach the RAM strictly in acceptance order.
- No read forwarding. A video read of an address with a queued write returns the old RAM contents.
- vid_valid: a register set to vid_req each edge. vid_data = ram_dout (combinational pass-through).
- No starvation guard. Video must leave idle cycles (blanking) for the FIFO to drain; this is an accepted limit.
- No state machine beyond the FIFO. Pointer, count and overflow updates all happen in one clocked process.

Test Plan:
- Reset: hold clr_n=0 mid-stream with 3 entries queued, then release → fifo_count=0, wr_ready=1, ram_we=0, wr_overflow=0. No write from the old entries appears afterwards.
- Idle drain, vid_req=0: push 'A'@0x010 at edge N → at cycle N+1, ram_we=1, ram_addr=0x010, ram_din=0x41; fifo_count back to 0 after edge N+1.
- Video priority: vid_req=1 for 10 cycles while pushing 4 writes ('0'..'3' @ 0x100..0x103):
  - ram_we=0 throughout, ram_addr=vid_addr;
  - fifo_count=4 and wr_ready=0 after the 4th push;
  - after vid_req drops, 4 consecutive ram_we pulses occur in order 0x100..0x103.
- Overflow: keep the FIFO full with vid_req=1 and push a 5th write 'X'@0x7FF → the write is dropped, wr_overflow=1 and stays 1. Then ovf_clr=1 for one edge → wr_overflow=0.
- Full push+pop: FIFO full, vid_req=0, wr_en=1 in the same cycle → the pop occurs, the push is dropped, wr_overflow=1, fifo_count=3 afterwards.
- Read path: vid_req=1, vid_addr=0x050, RAM[0x050]=0x5A → at the next cycle vid_valid=1 and vid_data=0x5A. A continuous vid_req stream streams one byte per cycle.

Source files
------------

// File: rtl/char_ram_arbiter.sv
// Character RAM port arbiter: video reads always win the single RAM port, while
// character writes wait in a small FIFO and drain on cycles video leaves idle.
module char_ram_arbiter #(
    parameter int ADDR_BITS = 11,
    parameter int DEPTH     = 4,
    parameter int PTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [7:0]           wr_char,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 wr_en,
    output logic                 wr_ready,
    output logic                 wr_overflow,
    input  logic                 ovf_clr,
    output logic [PTR_BITS:0]    fifo_count,
    input  logic                 vid_req,
    input  logic [ADDR_BITS-1:0] vid_addr,
    output logic [7:0]           vid_data,
    output logic                 vid_valid,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [7:0]           ram_din,
    output logic                 ram_we,
    input  logic [7:0]           ram_dout
);

    localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS + 1)'(DEPTH);
    localparam logic [PTR_BITS:0]   ZERO_COUNT = (PTR_BITS + 1)'(0);
    localparam logic [PTR_BITS:0]   ONE_COUNT  = (PTR_BITS + 1)'(1);
    localparam logic [PTR_BITS-1:0] ONE_PTR    = PTR_BITS'(1);

    logic [7:0]           char_mem_r [DEPTH];
    logic [ADDR_BITS-1:0] addr_mem_r [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_r;
    logic [PTR_BITS-1:0]  rd_ptr_r;
    logic [PTR_BITS:0]    count_r;
    logic                 overflow_r;
    logic                 vid_valid_r;

    logic                 wr_ready_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 drop_s;
    logic [ADDR_BITS-1:0] ram_addr_s;
    logic                 ram_we_s;

    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
    assign wr_ready_s = (count_r != FULL_COUNT);
    assign empty_s    = (count_r == ZERO_COUNT);

    // Classify the write request as accepted or dropped.
    always_comb begin
        push_s = 1'b0;
        drop_s = 1'b0;
        if (wr_en) begin
            push_s = wr_ready_s;
            drop_s = ~wr_ready_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // RAM port mux: video has absolute priority, queued writes use idle cycles.
    always_comb begin
        ram_addr_s = vid_addr;
        ram_we_s   = 1'b0;
        if (vid_req) begin
            ram_addr_s = vid_addr;
            ram_we_s   = 1'b0;
        end else if (!empty_s) begin
            ram_addr_s = addr_mem_r[rd_ptr_r];
            ram_we_s   = 1'b1;
        end else begin
            ram_addr_s = vid_addr;
            ram_we_s   = 1'b0;
        end
    end

    // FIFO payload storage; contents are qualified by count_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            char_mem_r[wr_ptr_r] <= wr_char;
            addr_mem_r[wr_ptr_r] <= wr_addr;
        end
    end

    // Pointers, occupancy, sticky overflow and the video valid pipeline stage.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_r    <= {PTR_BITS{1'b0}};
            rd_ptr_r    <= {PTR_BITS{1'b0}};
            count_r     <= ZERO_COUNT;
            overflow_r  <= 1'b0;
            vid_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (ram_we_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, ram_we_s})
                2'b10:   count_r <= count_r + ONE_COUNT;
                2'b01:   count_r <= count_r - ONE_COUNT;
                default: count_r <= count_r;
            endcase
            // A drop on the same edge as a clear must leave the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
            vid_valid_r <= vid_req;
        end
    end

    assign wr_ready    = wr_ready_s;
    assign wr_overflow = overflow_r;
    assign fifo_count  = count_r;
    assign vid_valid   = vid_valid_r;
    assign vid_data    = ram_dout;
    assign ram_addr    = ram_addr_s;
    assign ram_din     = char_mem_r[rd_ptr_r];
    assign ram_we      = ram_we_s;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Randomized scoreboard bench for char_ram_arbiter with a behavioural RAM and write-queue model.
module tb_char_ram_arbiter;

    localparam int AB    = 11;
    localparam int DEPTH = 4;
    localparam int PB    = 2;

    typedef struct packed {
        logic [7:0]    ch;
        logic [AB-1:0] addr;
    } wr_t;

    logic          clk = 1'b0;
    logic          clr_n;
    logic [7:0]    wr_char;
    logic [AB-1:0] wr_addr;
    logic          wr_en;
    logic          wr_ready;
    logic          wr_overflow;
    logic          ovf_clr;
    logic [PB:0]   fifo_count;
    logic          vid_req;
    logic [AB-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic [AB-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;

    int checks   = 0;
    int failures = 0;

    wr_t        pend[$];
    logic [7:0] rdq[$];
    logic [7:0] ref_mem [2048];
    logic [7:0] tb_ram  [2048];
    bit         exp_ovf  = 1'b0;
    bit         prev_req = 1'b0;

    char_ram_arbiter #(.ADDR_BITS(AB), .DEPTH(DEPTH), .PTR_BITS(PB)) dut (
        .clk(clk), .clr_n(clr_n), .wr_char(wr_char), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_overflow(wr_overflow), .ovf_clr(ovf_clr),
        .fifo_count(fifo_count), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_valid(vid_valid), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(int i);
        if (i == 32'h050) return 8'h5A;
        return 8'((i * 37) ^ (i >> 3));
    endfunction

    // Behavioural single-port RAM: synchronous read of the old contents.
    initial begin
        for (int i = 0; i < 2048; i++) tb_ram[i] = init_byte(i);
        ram_dout = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_we) tb_ram[ram_addr] <= ram_din;
            ram_dout <= tb_ram[ram_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: compares DUT outputs away from the active edge.
    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                pend.delete();
                rdq.delete();
                exp_ovf  = 1'b0;
                prev_req = 1'b0;
                chk("rst_count", int'(fifo_count), 0);
                chk("rst_vid_valid", int'(vid_valid), 0);
                chk("rst_overflow", int'(wr_overflow), 0);
            end else begin
                bit  exp_ready;
                bit  exp_we;
                wr_t w;
                exp_ready = (pend.size() != DEPTH);
                exp_we    = !vid_req && (pend.size() != 0);
                chk("wr_ready", int'(wr_ready), int'(exp_ready));
                chk("fifo_count", int'(fifo_count), pend.size());
                chk("ram_we", int'(ram_we), int'(exp_we));
                chk("wr_overflow", int'(wr_overflow), int'(exp_ovf));
                chk("vid_valid", int'(vid_valid), int'(prev_req));
                if (prev_req) begin
                    if (rdq.size() == 0) chk("read_queue_nonempty", 0, 1);
                    else chk("vid_data", int'(vid_data), int'(rdq.pop_front()));
                end
                if (exp_we) begin
                    w = pend.pop_front();
                    chk("wr_ram_addr", int'(ram_addr), int'(w.addr));
                    chk("wr_ram_din", int'(ram_din), int'(w.ch));
                    ref_mem[w.addr] = w.ch;
                end else begin
                    chk("vid_ram_addr", int'(ram_addr), int'(vid_addr));
                end
                if (vid_req) rdq.push_back(ref_mem[vid_addr]);
                if (wr_en && exp_ready) pend.push_back({wr_char, wr_addr});
                if (wr_en && !exp_ready) exp_ovf = 1'b1;
                else if (ovf_clr) exp_ovf = 1'b0;
                prev_req = vid_req;
            end
        end
    end

    task automatic drive(input bit we, input logic [7:0] ch, input logic [AB-1:0] a,
                         input bit vr, input logic [AB-1:0] va, input bit oc);
        @(posedge clk);
        #1;
        clr_n    = 1'b1;
        wr_en    = we;
        wr_char  = ch;
        wr_addr  = a;
        vid_req  = vr;
        vid_addr = va;
        ovf_clr  = oc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 11'h000, 1'b0, 11'h000, 1'b0);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1;
        clr_n = 1'b0;
        wr_en = 1'b0;
        vid_req = 1'b0;
        ovf_clr = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        bit vr;
        clr_n = 1'b0; wr_en = 1'b0; wr_char = 8'h00; wr_addr = 11'h000;
        vid_req = 1'b0; vid_addr = 11'h000; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        idle(2);

        // Idle drain of a single write
        drive(1'b1, 8'h41, 11'h010, 1'b0, 11'h000, 1'b0);
        idle(3);

        // Video priority, fill, overflow while full, overflow clear, then drain
        for (int i = 0; i < 10; i++) begin
            if (i < 4) drive(1'b1, 8'h30 + 8'(i), 11'h100 + 11'(i), 1'b1, 11'h200 + 11'(i), 1'b0);
            else if (i == 4) drive(1'b1, 8'h58, 11'h7FF, 1'b1, 11'h204, 1'b0);
            else drive(1'b0, 8'h00, 11'h000, 1'b1, 11'h200 + 11'(i), (i == 7));
        end
        idle(6);

        // Full FIFO: pop and push on the same cycle, push must drop
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hC0 + 8'(i), 11'h300 + 11'(i), 1'b1, 11'h000, 1'b0);
        drive(1'b1, 8'hEE, 11'h3FF, 1'b0, 11'h000, 1'b0);
        drive(1'b0, 8'h00, 11'h000, 1'b1, 11'h000, 1'b1);
        idle(5);

        // Reset with three queued writes: none may appear afterwards
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h70 + 8'(i), 11'h400 + 11'(i), 1'b1, 11'h000, 1'b0);
        pulse_reset(2);
        idle(5);

        // Read path: streaming video reads including 0x050
        for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 11'h000, 1'b1, 11'h050 + 11'(i), 1'b0);
        idle(2);

        // Randomized traffic with video bursts and occasional resets
        vr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) vr = ~vr;
            if ($urandom_range(0, 999) == 0) pulse_reset(1);
            else drive(1'($urandom_range(0, 1)), 8'($urandom), 11'($urandom_range(0, 63)),
                       vr, 11'($urandom_range(0, 63)), ($urandom_range(0, 15) == 0));
        end
        idle(8);
        chk("final_drained", pend.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
